// File: rtl/pie_preamble_rx_if.sv
// Envelope input and measurement/strobe outputs of the PIE receive front end.
// The master modport is the receiver; the slave is the upstream/downstream logic.
interface pie_preamble_rx_if;
  logic       demod_in;
  logic       rx_en;
  logic [9:0] TRcal;
  logic [9:0] RTcal;
  logic       blc_update;
  logic       frame_start;
  logic       preamble_flag;
  logic       bit_vld;
  logic       bit_data;
  logic       frame_end;
  logic       frame_err;

  modport master (
    input  demod_in,
    input  rx_en,
    output TRcal,
    output RTcal,
    output blc_update,
    output frame_start,
    output preamble_flag,
    output bit_vld,
    output bit_data,
    output frame_end,
    output frame_err
  );

  modport slave (
    output demod_in,
    output rx_en,
    input  TRcal,
    input  RTcal,
    input  blc_update,
    input  frame_start,
    input  preamble_flag,
    input  bit_vld,
    input  bit_data,
    input  frame_end,
    input  frame_err
  );
endinterface

// File: rtl/pie_preamble_rx.sv
// Gen2 reader-to-tag PIE front end: delimiter detect, Tari/RTcal/TRcal measurement
// and PIE bit decode, all timed in 1.92 MHz clock cycles.
module pie_preamble_rx #(
  parameter int unsigned DELIM_MIN = 19,
  parameter int unsigned DELIM_MAX = 29,
  parameter int unsigned DATA0_MIN = 10,
  parameter int unsigned DATA0_MAX = 50,
  parameter int unsigned TIMEOUT   = 1000
) (
  input logic               clk_1_92m,
  input logic               rst_n,
  pie_preamble_rx_if.master bus
);

  localparam logic [9:0] DelimMin = 10'(DELIM_MIN);
  localparam logic [9:0] DelimMax = 10'(DELIM_MAX);
  localparam logic [9:0] Data0Min = 10'(DATA0_MIN);
  localparam logic [9:0] Data0Max = 10'(DATA0_MAX);
  localparam logic [9:0] Timeout  = 10'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StDelim, StData0, StRtc, StTrc, StData} state_e;

  state_e     state_q, state_d;
  logic [1:0] sync_q;
  logic       demod_prev_q;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] d0_q, d0_d;
  logic [9:0] rtcal_q, rtcal_d;
  logic [9:0] trcal_q, trcal_d;
  logic       preamble_q, preamble_d;
  logic       bit_data_q, bit_data_d;
  logic       bit_vld_q, bit_vld_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_end_q, frame_end_d;
  logic       frame_err_q, frame_err_d;
  logic       blc_arm_q, blc_arm_d;
  logic       blc_update_q, blc_update_d;

  logic        rise, fall, timeout;
  logic [9:0]  ival, rt_half;
  logic [11:0] ival_x, rt3;

  assign rise    = sync_q[1] & ~demod_prev_q;
  assign fall    = ~sync_q[1] & demod_prev_q;
  // Interval is the saturating count including the current cycle.
  assign ival    = (cnt_q == 10'h3ff) ? cnt_q : cnt_q + 10'd1;
  assign timeout = (ival == Timeout);
  assign rt_half = rtcal_q >> 1;
  assign ival_x  = {2'b00, ival};
  assign rt3     = {2'b00, rtcal_q} + {1'b0, rtcal_q, 1'b0};

  always_comb begin
    state_d       = state_q;
    cnt_d         = ival;
    d0_d          = d0_q;
    rtcal_d       = rtcal_q;
    trcal_d       = trcal_q;
    preamble_d    = preamble_q;
    bit_data_d    = bit_data_q;
    bit_vld_d     = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_err_d   = 1'b0;
    blc_arm_d     = 1'b0;
    blc_update_d  = blc_arm_q;

    if (!bus.rx_en) begin
      state_d      = StIdle;
      cnt_d        = '0;
      blc_update_d = 1'b0;
    end else begin
      // Intervals run rising edge to rising edge; only the delimiter starts on a fall.
      if (rise) cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (fall) begin
            state_d = StDelim;
            cnt_d   = '0;
          end
        end
        StDelim: begin
          if (rise) begin
            if (ival >= DelimMin && ival <= DelimMax) begin
              state_d = StData0;
            end else begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
            end
          end
        end
        StData0: begin
          if (rise) begin
            if (ival >= Data0Min && ival <= Data0Max) begin
              d0_d    = ival;
              state_d = StRtc;
            end else begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
            end
          end else if (timeout) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
          end
        end
        StRtc: begin
          if (rise) begin
            if (ival > d0_q) begin
              rtcal_d = ival;
              state_d = StTrc;
            end else begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
            end
          end else if (timeout) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
          end
        end
        StTrc: begin
          if (rise) begin
            if (ival > rtcal_q && ival_x <= rt3) begin
              trcal_d       = ival;
              preamble_d    = 1'b1;
              frame_start_d = 1'b1;
              blc_arm_d     = 1'b1;
              state_d       = StData;
            end else if (ival > rtcal_q) begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
            end else begin
              // Frame-sync: this interval is already the first data bit.
              preamble_d    = 1'b0;
              frame_start_d = 1'b1;
              bit_vld_d     = 1'b1;
              bit_data_d    = (ival >= rt_half);
              state_d       = StData;
            end
          end else if (timeout) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
          end
        end
        StData: begin
          if (rise) begin
            bit_vld_d  = 1'b1;
            bit_data_d = (ival >= rt_half);
          end else if (timeout) begin
            state_d     = StIdle;
            frame_end_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sync_q        <= '0;
      demod_prev_q  <= 1'b0;
      cnt_q         <= '0;
      d0_q          <= '0;
      rtcal_q       <= '0;
      trcal_q       <= '0;
      preamble_q    <= 1'b0;
      bit_data_q    <= 1'b0;
      bit_vld_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      blc_arm_q     <= 1'b0;
      blc_update_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[0], bus.demod_in};
      demod_prev_q  <= sync_q[1];
      cnt_q         <= cnt_d;
      d0_q          <= d0_d;
      rtcal_q       <= rtcal_d;
      trcal_q       <= trcal_d;
      preamble_q    <= preamble_d;
      bit_data_q    <= bit_data_d;
      bit_vld_q     <= bit_vld_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_err_q   <= frame_err_d;
      blc_arm_q     <= blc_arm_d;
      blc_update_q  <= blc_update_d;
    end
  end

  assign bus.TRcal         = trcal_q;
  assign bus.RTcal         = rtcal_q;
  assign bus.blc_update    = blc_update_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.preamble_flag = preamble_q;
  assign bus.bit_vld       = bit_vld_q;
  assign bus.bit_data      = bit_data_q;
  assign bus.frame_end     = frame_end_q;
  assign bus.frame_err     = frame_err_q;

endmodule

// File: tb/tb_pie_preamble_rx.sv
// Self-checking bench for pie_preamble_rx: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_pie_preamble_rx;

  localparam int Pw = 3;  // low-pulse width of each PIE symbol, in cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pie_preamble_rx_if bus_if ();

  pie_preamble_rx #(
    .DELIM_MIN(19),
    .DELIM_MAX(29),
    .DATA0_MIN(10),
    .DATA0_MAX(50),
    .TIMEOUT  (1000)
  ) dut (
    .clk_1_92m(clk),
    .rst_n    (rst_n),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Event monitor, sampled on the falling edge.
  int cyc = 0, n_fs = 0, n_err = 0, n_end = 0, n_blc = 0;
  int fs_cyc = 0, blc_cyc = 0, fs_pre = 0, fs_bit = 0, fs_trcal = 0, blc_trcal = 0;
  bit mon_bits[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.frame_start) begin
      n_fs     <= n_fs + 1;
      fs_cyc   <= cyc;
      fs_pre   <= int'(bus_if.preamble_flag);
      fs_bit   <= int'(bus_if.bit_vld);
      fs_trcal <= int'(bus_if.TRcal);
    end
    if (bus_if.blc_update) begin
      n_blc     <= n_blc + 1;
      blc_cyc   <= cyc;
      blc_trcal <= int'(bus_if.TRcal);
    end
    if (bus_if.bit_vld) mon_bits.push_back(bus_if.bit_data);
    if (bus_if.frame_err) n_err <= n_err + 1;
    if (bus_if.frame_end) n_end <= n_end + 1;
  end

  // Expected calibration registers, tracked by the bench.
  int exp_tr = 0, exp_rt = 0;
  bit exp_bits[$];

  task automatic cyc_wait(input int k);
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
  endtask

  // Delimiter of dl low cycles, then rising edges spaced by iv[0..n-1].
  task automatic send(input int dl, input int iv[$], input int n);
    bus_if.demod_in = 1'b0;
    cyc_wait(dl);
    bus_if.demod_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc_wait(iv[i] - Pw);
      bus_if.demod_in = 1'b0;
      cyc_wait(Pw);
      bus_if.demod_in = 1'b1;
    end
    cyc_wait(8);
  endtask

  task automatic end_frame();
    bus_if.rx_en = 1'b0;
    cyc_wait(3);
    bus_if.rx_en = 1'b1;
    cyc_wait(3);
  endtask

  // Frame-level model: decides how far a frame gets and what it should produce.
  task automatic model(input int dl, d0, rt, x, input int b[$], output int ns,
                       output int e_err, output int e_fs, output int e_pre, output int e_blc);
    e_err = 0; e_fs = 0; e_pre = 0; e_blc = 0;
    exp_bits.delete();
    if (dl < 19 || dl > 29) begin ns = 0; e_err = 1; return; end
    if (d0 < 10 || d0 > 50) begin ns = 1; e_err = 1; return; end
    if (rt <= d0) begin ns = 2; e_err = 1; return; end
    exp_rt = rt;
    if (x > rt && x <= 3 * rt) begin
      ns = 3 + b.size(); e_fs = 1; e_pre = 1; e_blc = 1; exp_tr = x;
    end else if (x > rt) begin
      ns = 3; e_err = 1; return;
    end else begin
      ns = 3 + b.size(); e_fs = 1; e_pre = 0;
      exp_bits.push_back(x >= rt / 2);
    end
    foreach (b[i]) exp_bits.push_back(b[i] >= rt / 2);
  endtask

  task automatic test_reset();
    bus_if.demod_in = 1'b1;
    bus_if.rx_en    = 1'b1;
    #12;
    checks++;
    if (bus_if.TRcal !== 10'd0) $display("FAIL reset_trcal: got %0d want 0", bus_if.TRcal);
    else passes++;
    checks++;
    if (bus_if.RTcal !== 10'd0) $display("FAIL reset_rtcal: got %0d want 0", bus_if.RTcal);
    else passes++;
    checks++;
    if ({bus_if.blc_update, bus_if.frame_start, bus_if.preamble_flag, bus_if.bit_vld,
         bus_if.bit_data, bus_if.frame_end, bus_if.frame_err} !== 7'd0)
      $display("FAIL reset_flags: got nonzero want 0");
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc_wait(6);
  endtask

  task automatic test_preamble();
    int fs0 = n_fs, blc0 = n_blc, err0 = n_err;
    send(24, '{12, 36, 96}, 3);
    exp_tr = 96; exp_rt = 36;
    checks++;
    if (n_fs - fs0 !== 1) $display("FAIL pre_fs_count: got %0d want 1", n_fs - fs0);
    else passes++;
    checks++;
    if (fs_trcal !== 96) $display("FAIL pre_trcal_at_fs: got %0d want 96", fs_trcal);
    else passes++;
    checks++;
    if (bus_if.RTcal !== 10'd36) $display("FAIL pre_rtcal: got %0d want 36", bus_if.RTcal);
    else passes++;
    checks++;
    if (fs_pre !== 1) $display("FAIL pre_flag: got %0d want 1", fs_pre);
    else passes++;
    checks++;
    if (n_blc - blc0 !== 1 || blc_cyc - fs_cyc !== 1)
      $display("FAIL pre_blc: got count %0d delay %0d want 1 1", n_blc - blc0, blc_cyc - fs_cyc);
    else passes++;
    checks++;
    if (n_err !== err0) $display("FAIL pre_err: got %0d want 0", n_err - err0);
    else passes++;
    end_frame();
  endtask

  task automatic test_frame_sync_bits();
    int fs0 = n_fs, blc0 = n_blc, bi = mon_bits.size();
    send(24, '{12, 36, 12, 24, 12}, 5);
    checks++;
    if (n_fs - fs0 !== 1 || fs_bit !== 1 || fs_pre !== 0)
      $display("FAIL fsync_start: got fs %0d bit %0d pre %0d want 1 1 0", n_fs - fs0, fs_bit,
               fs_pre);
    else passes++;
    checks++;
    if (mon_bits.size() - bi !== 3)
      $display("FAIL fsync_nbits: got %0d want 3", mon_bits.size() - bi);
    else if ({mon_bits[bi], mon_bits[bi+1], mon_bits[bi+2]} !== 3'b010)
      $display("FAIL fsync_bits: got %b%b%b want 010", mon_bits[bi], mon_bits[bi+1],
               mon_bits[bi+2]);
    else passes++;
    checks++;
    if (bus_if.TRcal !== 10'(exp_tr) || n_blc !== blc0)
      $display("FAIL fsync_trcal: got %0d blc %0d want %0d 0", bus_if.TRcal, n_blc - blc0,
               exp_tr);
    else passes++;
    end_frame();
  endtask

  task automatic test_bad_delim();
    int lows[2] = '{15, 35};
    foreach (lows[i]) begin
      int err0 = n_err, fs0 = n_fs;
      send(lows[i], '{12}, 0);
      checks++;
      if (n_err - err0 !== 1 || n_fs !== fs0)
        $display("FAIL bad_delim_%0d: got err %0d fs %0d want 1 0", lows[i], n_err - err0,
                 n_fs - fs0);
      else passes++;
    end
    begin
      int fs0 = n_fs;
      send(24, '{12, 36, 96}, 3);
      checks++;
      if (n_fs - fs0 !== 1) $display("FAIL bad_delim_recover: got %0d want 1", n_fs - fs0);
      else passes++;
      end_frame();
    end
  endtask

  task automatic test_trcal_range();
    int err0 = n_err, fs0 = n_fs;
    send(24, '{12, 36, 120}, 3);
    checks++;
    if (n_err - err0 !== 1 || n_fs !== fs0)
      $display("FAIL trc_range: got err %0d fs %0d want 1 0", n_err - err0, n_fs - fs0);
    else passes++;
    checks++;
    if (bus_if.TRcal !== 10'(exp_tr))
      $display("FAIL trc_range_hold: got %0d want %0d", bus_if.TRcal, exp_tr);
    else passes++;
  endtask

  task automatic test_rx_en_abort();
    int tot0;
    send(24, '{12, 40}, 2);
    exp_rt = 40;
    tot0 = n_fs + n_err + n_end + n_blc + mon_bits.size();
    bus_if.rx_en = 1'b0;
    cyc_wait(4);
    bus_if.rx_en = 1'b1;
    cyc_wait(1100);
    checks++;
    if (n_fs + n_err + n_end + n_blc + mon_bits.size() !== tot0)
      $display("FAIL rx_en_abort_strobes: got %0d want 0",
               n_fs + n_err + n_end + n_blc + mon_bits.size() - tot0);
    else passes++;
    checks++;
    if (bus_if.RTcal !== 10'(exp_rt) || bus_if.TRcal !== 10'(exp_tr))
      $display("FAIL rx_en_abort_cal: got %0d/%0d want %0d/%0d", bus_if.RTcal, bus_if.TRcal,
               exp_rt, exp_tr);
    else passes++;
  endtask

  task automatic test_timeout();
    int end0, err0, waited, fs0;
    send(24, '{12, 36, 96, 12, 24}, 5);
    exp_tr = 96; exp_rt = 36;
    end0 = n_end; err0 = n_err; waited = 0;
    while (n_end == end0 && waited < 1100) begin
      cyc_wait(1);
      waited++;
    end
    cyc_wait(20);
    checks++;
    if (n_end - end0 !== 1 || n_err !== err0)
      $display("FAIL timeout_end: got end %0d err %0d want 1 0", n_end - end0, n_err - err0);
    else passes++;
    checks++;
    if (waited < 994 || waited > 998)
      $display("FAIL timeout_delay: got %0d want 994..998", waited);
    else passes++;
    fs0 = n_fs;
    send(24, '{12, 36, 80}, 3);
    exp_tr = 80;
    checks++;
    if (n_fs - fs0 !== 1 || bus_if.TRcal !== 10'd80)
      $display("FAIL timeout_next: got fs %0d trcal %0d want 1 80", n_fs - fs0, bus_if.TRcal);
    else passes++;
    end_frame();
  endtask

  task automatic test_reset_mid();
    int blc0;
    bus_if.demod_in = 1'b0;
    cyc_wait(24);
    bus_if.demod_in = 1'b1;
    cyc_wait(12 - Pw);
    bus_if.demod_in = 1'b0;
    cyc_wait(Pw);
    bus_if.demod_in = 1'b1;
    cyc_wait(10);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.TRcal, bus_if.RTcal} !== 20'd0)
      $display("FAIL rst_mid_cal: got %0d/%0d want 0/0", bus_if.TRcal, bus_if.RTcal);
    else passes++;
    checks++;
    if ({bus_if.blc_update, bus_if.frame_start, bus_if.preamble_flag, bus_if.bit_vld,
         bus_if.bit_data, bus_if.frame_end, bus_if.frame_err} !== 7'd0)
      $display("FAIL rst_mid_flags: got nonzero want 0");
    else passes++;
    cyc_wait(3);
    rst_n = 1'b1;
    cyc_wait(5);
    exp_tr = 0; exp_rt = 0;
    blc0 = n_blc;
    send(24, '{12, 36, 64}, 3);
    exp_tr = 64; exp_rt = 36;
    checks++;
    if (n_blc - blc0 !== 1 || blc_trcal !== 64)
      $display("FAIL rst_mid_blc: got count %0d trcal %0d want 1 64", n_blc - blc0, blc_trcal);
    else passes++;
    end_frame();
  endtask

  int t_dl[14] = '{19, 29, 18, 30, 24, 24, 24, 24, 24, 24, 24, 24, 24, 24};
  int t_d0[14] = '{12, 12, 12, 12, 10, 50, 9, 51, 12, 12, 12, 12, 12, 12};
  int t_rt[14] = '{36, 36, 36, 36, 36, 60, 36, 60, 12, 36, 36, 36, 36, 36};
  int t_x[14]  = '{96, 96, 96, 96, 108, 180, 96, 96, 96, 109, 37, 36, 17, 18};

  task automatic test_random();
    for (int f = 0; f < 74; f++) begin
      int dl, d0, rt, x, nb, ns, e_err, e_fs, e_pre, e_blc;
      int err0, fs0, blc0, bi;
      int b[$];
      int iv[$];
      bit [7:0] got_v, exp_v;
      if (f < 14) begin
        dl = t_dl[f]; d0 = t_d0[f]; rt = t_rt[f]; x = t_x[f];
      end else begin
        dl = ($urandom_range(3, 0) == 0) ? int'($urandom_range(36, 12))
                                         : int'($urandom_range(29, 19));
        d0 = ($urandom_range(4, 0) == 0) ? int'($urandom_range(60, 6))
                                         : int'($urandom_range(50, 10));
        rt = ($urandom_range(9, 0) == 0) ? int'($urandom_range(d0, 6))
                                         : int'($urandom_range(d0 + 120, d0 + 1));
        case ($urandom_range(3, 0))
          0, 1:    x = int'($urandom_range(3 * rt, rt + 1));
          2:       x = int'($urandom_range(3 * rt + 40, 3 * rt + 1));
          default: x = int'($urandom_range(rt, 6));
        endcase
      end
      nb = int'($urandom_range(4, 0));
      for (int i = 0; i < nb; i++) b.push_back(int'($urandom_range(rt + rt / 2, 6)));
      iv = {d0, rt, x};
      foreach (b[i]) iv.push_back(b[i]);
      model(dl, d0, rt, x, b, ns, e_err, e_fs, e_pre, e_blc);
      err0 = n_err; fs0 = n_fs; blc0 = n_blc; bi = mon_bits.size();
      send(dl, iv, ns);
      checks++;
      if (n_err - err0 !== e_err || n_fs - fs0 !== e_fs || n_blc - blc0 !== e_blc)
        $display("FAIL rnd%0d_events: got err %0d fs %0d blc %0d want %0d %0d %0d", f,
                 n_err - err0, n_fs - fs0, n_blc - blc0, e_err, e_fs, e_blc);
      else passes++;
      checks++;
      if (bus_if.TRcal !== 10'(exp_tr) || bus_if.RTcal !== 10'(exp_rt))
        $display("FAIL rnd%0d_cal: got %0d/%0d want %0d/%0d", f, bus_if.TRcal, bus_if.RTcal,
                 exp_tr, exp_rt);
      else passes++;
      got_v = '0; exp_v = '0;
      for (int i = bi; i < mon_bits.size() && i - bi < 8; i++) got_v[i-bi] = mon_bits[i];
      foreach (exp_bits[i]) exp_v[i] = exp_bits[i];
      checks++;
      if (mon_bits.size() - bi !== exp_bits.size() || got_v !== exp_v)
        $display("FAIL rnd%0d_bits: got n=%0d %b want n=%0d %b", f, mon_bits.size() - bi,
                 got_v, exp_bits.size(), exp_v);
      else passes++;
      if (e_fs == 1) begin
        checks++;
        if (fs_pre !== e_pre || fs_bit !== 1 - e_pre)
          $display("FAIL rnd%0d_kind: got pre %0d bit %0d want %0d %0d", f, fs_pre, fs_bit,
                   e_pre, 1 - e_pre);
        else passes++;
      end
      end_frame();
    end
  endtask

  initial begin
    test_reset();
    test_preamble();
    test_frame_sync_bits();
    test_bad_delim();
    test_trcal_range();
    test_rx_en_abort();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
